// File: rtl/version_slot_store.sv
// Four-slot (version, data) store feeding priorityRouter; slot outputs update one cycle after a write/invalidate edge.
// Writes stall (wrReady low) while a round-robin victim waits in EVICT for evictReady; the victim is held stable meanwhile.
module version_slot_store #(
    parameter int BLOCK_SIZE = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wrValid,
    output logic                  wrReady,
    input  logic [BLOCK_SIZE-1:0] wrVersion,
    input  logic [DATA_WIDTH-1:0] wrData,
    input  logic                  invValid,
    input  logic [BLOCK_SIZE-1:0] invVersion,
    output logic                  evictValid,
    input  logic                  evictReady,
    output logic [BLOCK_SIZE-1:0] evictVersion,
    output logic [DATA_WIDTH-1:0] evictData,
    output logic [3:0]            slotValid,
    output logic [BLOCK_SIZE-1:0] version0,
    output logic [BLOCK_SIZE-1:0] version1,
    output logic [BLOCK_SIZE-1:0] version2,
    output logic [BLOCK_SIZE-1:0] version3,
    output logic [DATA_WIDTH-1:0] dataOut0,
    output logic [DATA_WIDTH-1:0] dataOut1,
    output logic [DATA_WIDTH-1:0] dataOut2,
    output logic [DATA_WIDTH-1:0] dataOut3
);

    localparam logic [BLOCK_SIZE-1:0] EMPTY_TAG = '1;

    typedef enum logic {IDLE, EVICT} state_t;

    state_t                state;
    state_t                nextState;
    logic [BLOCK_SIZE-1:0] slotTag  [4];
    logic [DATA_WIDTH-1:0] slotData [4];
    logic [3:0]            valid;
    logic [1:0]            evictPtr;
    logic [BLOCK_SIZE-1:0] pendVersion;
    logic [DATA_WIDTH-1:0] pendData;

    logic       wrFire;
    logic       wrUseful;
    logic [3:0] hitVec;
    logic [3:0] invVec;
    logic [3:0] wrSet;
    logic       hit;
    logic       full;
    logic [1:0] freeIdx;
    logic       goEvict;
    logic       evictFire;

    always_comb begin
        wrFire    = wrValid && wrReady;
        wrUseful  = wrFire && (wrVersion != EMPTY_TAG);
        hitVec    = '0;
        invVec    = '0;
        wrSet     = '0;
        freeIdx   = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            hitVec[i] = valid[i] && (slotTag[i] == wrVersion);
            // The victim is overwritten by the pending write, so invalidating it is moot.
            invVec[i] = invValid && valid[i] && (slotTag[i] == invVersion)
                        && !(state == EVICT && evictPtr == 2'(i));
            if (!valid[i]) freeIdx = 2'(i);
        end
        hit       = |hitVec;
        full      = &valid;
        for (int i = 0; i < 4; i++) begin
            wrSet[i] = wrUseful && (hitVec[i] || (!hit && !full && freeIdx == 2'(i)));
        end
        goEvict   = wrUseful && !hit && full;
        evictFire = (state == EVICT) && evictReady;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (goEvict)    nextState = EVICT;
            EVICT:   if (evictReady) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        wrReady    = (state == IDLE) && !rst;
        evictValid = (state == EVICT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid       <= '0;
            evictPtr    <= 2'd0;
            pendVersion <= '0;
            pendData    <= '0;
            for (int i = 0; i < 4; i++) begin
                slotTag[i]  <= EMPTY_TAG;
                slotData[i] <= '0;
            end
        end else begin
            // Write set after invalidate clear so a same-tag write wins.
            valid <= (valid & ~invVec) | wrSet;
            for (int i = 0; i < 4; i++) begin
                if (wrSet[i]) begin
                    slotTag[i]  <= wrVersion;
                    slotData[i] <= wrData;
                end
            end
            if (goEvict) begin
                pendVersion <= wrVersion;
                pendData    <= wrData;
            end
            if (evictFire) begin
                slotTag[evictPtr]  <= pendVersion;
                slotData[evictPtr] <= pendData;
                evictPtr           <= evictPtr + 2'd1;
            end
        end
    end

    assign evictVersion = slotTag[evictPtr];
    assign evictData    = slotData[evictPtr];
    assign slotValid    = valid;
    assign version0     = valid[0] ? slotTag[0] : EMPTY_TAG;
    assign version1     = valid[1] ? slotTag[1] : EMPTY_TAG;
    assign version2     = valid[2] ? slotTag[2] : EMPTY_TAG;
    assign version3     = valid[3] ? slotTag[3] : EMPTY_TAG;
    assign dataOut0     = valid[0] ? slotData[0] : '0;
    assign dataOut1     = valid[1] ? slotData[1] : '0;
    assign dataOut2     = valid[2] ? slotData[2] : '0;
    assign dataOut3     = valid[3] ? slotData[3] : '0;

endmodule

// File: tb/tb_version_slot_store.sv
// Directed bench for version_slot_store: fill, evict with backpressure, hit, write/invalidate race, drop tag, reset in EVICT.
module tb_version_slot_store;

    logic        clk = 1'b0;
    logic        rst;
    logic        wrValid;
    logic        wrReady;
    logic [3:0]  wrVersion;
    logic [31:0] wrData;
    logic        invValid;
    logic [3:0]  invVersion;
    logic        evictValid;
    logic        evictReady;
    logic [3:0]  evictVersion;
    logic [31:0] evictData;
    logic [3:0]  slotValid;
    logic [3:0]  version0, version1, version2, version3;
    logic [31:0] dataOut0, dataOut1, dataOut2, dataOut3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    version_slot_store #(.BLOCK_SIZE(4), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .wrValid(wrValid), .wrReady(wrReady), .wrVersion(wrVersion), .wrData(wrData),
        .invValid(invValid), .invVersion(invVersion),
        .evictValid(evictValid), .evictReady(evictReady),
        .evictVersion(evictVersion), .evictData(evictData),
        .slotValid(slotValid),
        .version0(version0), .version1(version1), .version2(version2), .version3(version3),
        .dataOut0(dataOut0), .dataOut1(dataOut1), .dataOut2(dataOut2), .dataOut3(dataOut3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] v, input logic [31:0] d);
        wrValid = 1'b1; wrVersion = v; wrData = d;
        step();
        wrValid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; wrValid = 1'b0; wrVersion = '0; wrData = '0;
        invValid = 1'b0; invVersion = '0; evictReady = 1'b0;
        step(); step();
        chk("rst_slotValid", 32'(slotValid), 32'h0);
        chk("rst_evictValid", 32'(evictValid), 32'h0);
        chk("rst_version0", 32'(version0), 32'hF);
        chk("rst_dataOut3", dataOut3, 32'h0);
        chk("rst_wrReady_low", 32'(wrReady), 32'h0);
        rst = 1'b0;
        #1;
        chk("wrReady_after_rst", 32'(wrReady), 32'h1);

        // 1: fill four slots
        for (int v = 1; v <= 4; v++) begin
            wr(4'(v), 32'hA0 + 32'(v));
            chk("fill_evictValid", 32'(evictValid), 32'h0);
        end
        chk("fill_slotValid", 32'(slotValid), 32'hF);
        chk("fill_version0", 32'(version0), 32'h1);
        chk("fill_version1", 32'(version1), 32'h2);
        chk("fill_version2", 32'(version2), 32'h3);
        chk("fill_version3", 32'(version3), 32'h4);
        chk("fill_dataOut3", dataOut3, 32'hA4);

        // 2: miss while full, eviction held by backpressure
        wr(4'h5, 32'hB5);
        chk("evict_wrReady", 32'(wrReady), 32'h0);
        chk("evict_valid", 32'(evictValid), 32'h1);
        chk("evict_version", 32'(evictVersion), 32'h1);
        chk("evict_data", evictData, 32'hA1);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("hold_valid", 32'(evictValid), 32'h1);
            chk("hold_version", 32'(evictVersion), 32'h1);
            chk("hold_data", evictData, 32'hA1);
        end
        evictReady = 1'b1;
        step();
        evictReady = 1'b0;
        chk("evdone_version0", 32'(version0), 32'h5);
        chk("evdone_dataOut0", dataOut0, 32'hB5);
        chk("evdone_wrReady", 32'(wrReady), 32'h1);
        chk("evdone_evictValid", 32'(evictValid), 32'h0);
        chk("evdone_slotValid", 32'(slotValid), 32'hF);

        // 3: hit while full
        wr(4'h2, 32'hC2);
        chk("hit_dataOut1", dataOut1, 32'hC2);
        chk("hit_evictValid", 32'(evictValid), 32'h0);
        chk("hit_wrReady", 32'(wrReady), 32'h1);

        // 4: write beats same-tag invalidate, then invalidate alone
        invValid = 1'b1; invVersion = 4'h3;
        wr(4'h3, 32'hD3);
        invValid = 1'b0;
        chk("race_slotValid", 32'(slotValid), 32'hF);
        chk("race_dataOut2", dataOut2, 32'hD3);
        invValid = 1'b1; invVersion = 4'h3;
        step();
        invValid = 1'b0;
        chk("inv_slotValid", 32'(slotValid), 32'hB);
        chk("inv_version2", 32'(version2), 32'hF);
        chk("inv_dataOut2", dataOut2, 32'h0);

        // 5: reserved tag dropped; lowest free slot filled
        wr(4'hF, 32'h99);
        chk("drop_slotValid", 32'(slotValid), 32'hB);
        chk("drop_version2", 32'(version2), 32'hF);
        chk("drop_wrReady", 32'(wrReady), 32'h1);
        invValid = 1'b1; invVersion = 4'h2;
        step();
        invValid = 1'b0;
        chk("free1_slotValid", 32'(slotValid), 32'h9);
        wr(4'h7, 32'hE7);
        chk("fill1_slotValid", 32'(slotValid), 32'hB);
        chk("fill1_version1", 32'(version1), 32'h7);
        chk("fill1_version0", 32'(version0), 32'h5);
        chk("fill1_dataOut1", dataOut1, 32'hE7);

        // 6: second eviction uses pointer 1; victim invalidate ignored; reset in EVICT
        wr(4'h8, 32'hF8);
        chk("fill2_slotValid", 32'(slotValid), 32'hF);
        wr(4'h9, 32'hF9);
        chk("ev2_version", 32'(evictVersion), 32'h7);
        chk("ev2_data", evictData, 32'hE7);
        invValid = 1'b1; invVersion = 4'h7;
        step();
        invValid = 1'b0;
        chk("vicinv_slotValid", 32'(slotValid), 32'hF);
        chk("vicinv_evictValid", 32'(evictValid), 32'h1);
        rst = 1'b1;
        step();
        chk("rstev_evictValid", 32'(evictValid), 32'h0);
        chk("rstev_slotValid", 32'(slotValid), 32'h0);
        rst = 1'b0;
        #1;
        chk("rstev_wrReady", 32'(wrReady), 32'h1);
        for (int v = 1; v <= 4; v++) wr(4'(v), 32'h10 + 32'(v));
        chk("refill_version0", 32'(version0), 32'h1);
        wr(4'h6, 32'h16);
        chk("ptr0_evictVersion", 32'(evictVersion), 32'h1);
        chk("ptr0_evictData", evictData, 32'h11);
        evictReady = 1'b1;
        step();
        evictReady = 1'b0;
        chk("ptr0_version0", 32'(version0), 32'h6);
        chk("ptr0_version1", 32'(version1), 32'h2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
